// File: rtl/lm07_spi_responder.sv
// LM07 temperature sensor serial responder: oversamples cs_n/sck on clk
// and shifts out {temp, 3'b111} MSB first on each synced sck fall.
module lm07_spi_responder #(
    parameter int TEMP_W      = 13,
    parameter int FRAME_BITS  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs_n_i,
    input  logic              sck_i,
    input  logic [TEMP_W-1:0] temp_i,
    output logic              so_o,
    output logic              so_oe_o,
    output logic              busy_o,
    output logic              frame_done_o
);

    localparam int CNT_W = $clog2(FRAME_BITS + 1);
    localparam int PAD_W = FRAME_BITS - TEMP_W;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] sck_sync;
    logic                   cs_d;
    logic                   sck_d;
    logic [FRAME_BITS-1:0]  shift_reg;
    logic [CNT_W-1:0]       bit_cnt;

    logic cs_s;
    logic sck_s;
    logic cs_fall;
    logic cs_rise;
    logic sck_fall;

    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign cs_fall  = cs_d & ~cs_s;
    assign cs_rise  = ~cs_d & cs_s;
    assign sck_fall = sck_d & ~sck_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_sync  <= '1;
            sck_sync <= '0;
            cs_d     <= 1'b1;
            sck_d    <= 1'b0;
        end else begin
            cs_sync  <= {cs_sync[SYNC_STAGES-2:0], cs_n_i};
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck_i};
            cs_d     <= cs_s;
            sck_d    <= sck_s;
        end
    end

    // CS rise beats everything; a CS fall load swallows a same-cycle sck fall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            shift_reg    <= '0;
            bit_cnt      <= '0;
            so_o         <= 1'b0;
            so_oe_o      <= 1'b0;
            busy_o       <= 1'b0;
            frame_done_o <= 1'b0;
        end else begin
            frame_done_o <= 1'b0;
            busy_o       <= ~cs_s;
            so_o         <= (state == SHIFT) ? shift_reg[FRAME_BITS-1] : 1'b0;
            so_oe_o      <= (state != IDLE);
            if (cs_rise) begin
                state <= IDLE;
            end else if (cs_fall) begin
                state     <= SHIFT;
                shift_reg <= {temp_i, {PAD_W{1'b1}}};
                bit_cnt   <= '0;
            end else if (state == SHIFT && sck_fall) begin
                shift_reg <= {shift_reg[FRAME_BITS-2:0], 1'b0};
                bit_cnt   <= bit_cnt + 1'b1;
                if (bit_cnt == CNT_W'(FRAME_BITS - 1)) begin
                    state        <= DONE;
                    frame_done_o <= 1'b1;
                end
            end
        end
    end

endmodule
